// File: rtl/keccak_chi_ctrl.sv
// Controller that feeds shared chi rows through an external masked sbox.
// Each row is fetched together with one fresh-mask word, evaluated by the
// sbox, and the expanded (D+1)^2 output shares per lane are compressed back
// to D+1 shares and written to the result buffer.
module keccak_chi_ctrl #(
  parameter int D    = 3,
  parameter int ROWS = 8
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       start,
  input  logic [ROWS*5*(D+1)-1:0]    in_rows,
  input  logic                       rnd_valid,
  input  logic [5*D*(D+1)/2-1:0]     rnd_data,
  output logic                       rnd_ready,
  output logic [D:0]                 sb_a,
  output logic [D:0]                 sb_b,
  output logic [D:0]                 sb_c,
  output logic [D:0]                 sb_d,
  output logic [D:0]                 sb_e,
  output logic [5*D*(D+1)/2-1:0]     sb_r,
  input  logic [(D+1)*(D+1)-1:0]     sb_ap,
  input  logic [(D+1)*(D+1)-1:0]     sb_bp,
  input  logic [(D+1)*(D+1)-1:0]     sb_cp,
  input  logic [(D+1)*(D+1)-1:0]     sb_dp,
  input  logic [(D+1)*(D+1)-1:0]     sb_ep,
  output logic [ROWS*5*(D+1)-1:0]    out_rows,
  output logic                       busy,
  output logic                       done
);

  localparam int SH   = D + 1;
  localparam int RW   = 5 * SH;
  localparam int RNDW = 5 * D * (D + 1) / 2;
  localparam int EXW  = SH * SH;
  localparam int CW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EVAL     = 3'd2,
    ST_COMPRESS = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          row_q, row_d;
  logic [ROWS*RW-1:0]     buf_q, buf_d;
  logic [ROWS*RW-1:0]     out_q, out_d;
  logic [4:0][SH-1:0]     lane_q, lane_d;
  logic [4:0][EXW-1:0]    exp_q, exp_d;
  logic [RNDW-1:0]        rnd_q, rnd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rdy_q, rdy_d;

  // Share i of a lane is the XOR of expanded row i (bits i*SH .. i*SH+D).
  function automatic logic [SH-1:0] compress_lane(input logic [EXW-1:0] e);
    logic [SH-1:0] acc;
    acc = '0;
    for (int i = 0; i < SH; i++) begin
      for (int j = 0; j < SH; j++) begin
        acc[i] = acc[i] ^ e[i*SH+j];
      end
    end
    return acc;
  endfunction

  // Next-state logic; status outputs are precomputed from the next state so
  // they are registered yet aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    buf_d   = buf_q;
    out_d   = out_q;
    lane_d  = lane_q;
    exp_d   = exp_q;
    rnd_d   = rnd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d   = in_rows;
          row_d   = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (rnd_valid) begin
          rnd_d = rnd_data;
          for (int l = 0; l < 5; l++) begin
            lane_d[l] = buf_q[int'(row_q)*RW + l*SH +: SH];
          end
          state_d = ST_EVAL;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EVAL: begin
        exp_d[0] = sb_ap;
        exp_d[1] = sb_bp;
        exp_d[2] = sb_cp;
        exp_d[3] = sb_dp;
        exp_d[4] = sb_ep;
        state_d  = ST_COMPRESS;
      end
      ST_COMPRESS: begin
        for (int l = 0; l < 5; l++) begin
          out_d[int'(row_q)*RW + l*SH +: SH] = compress_lane(exp_q[l]);
        end
        // Masks are single-use: drop them once the sbox result is captured.
        rnd_d = '0;
        if (row_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + CW'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE)  ? 1'b1 : 1'b0;
    done_d = (state_d == ST_DONE)  ? 1'b1 : 1'b0;
    rdy_d  = (state_d == ST_FETCH) ? 1'b1 : 1'b0;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      lane_q  <= '0;
      exp_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      lane_q  <= lane_d;
      exp_q   <= exp_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign sb_a      = lane_q[0];
  assign sb_b      = lane_q[1];
  assign sb_c      = lane_q[2];
  assign sb_d      = lane_q[3];
  assign sb_e      = lane_q[4];
  assign sb_r      = rnd_q;
  assign out_rows  = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rnd_ready = rdy_q;

endmodule

// File: tb/tb_keccak_chi_ctrl.sv
// Directed bench for keccak_chi_ctrl with a behavioural masked chi sbox.
module tb_keccak_chi_ctrl;
  localparam int D    = 3;
  localparam int ROWS = 8;
  localparam int SH   = 4;
  localparam int RW   = 20;
  localparam int RNDW = 30;
  localparam int EXW  = 16;
  localparam int W    = ROWS * RW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rnd_valid = 1'b0;
  logic [W-1:0] in_rows = '0;
  logic [W-1:0] out_rows;
  logic [RNDW-1:0] rnd_data = '0;
  logic [RNDW-1:0] sb_r;
  logic rnd_ready, busy, done;
  logic [SH-1:0] sb_a, sb_b, sb_c, sb_d, sb_e;
  logic [EXW-1:0] sb_ap, sb_bp, sb_cp, sb_dp, sb_ep;

  logic start1 = 1'b0;
  logic rnd_valid1 = 1'b0;
  logic [RW-1:0] in_rows1 = '0;
  logic [RW-1:0] out_rows1;
  logic [RNDW-1:0] rnd_data1 = '0;
  logic [RNDW-1:0] sb_r1;
  logic rnd_ready1, busy1, done1;
  logic [SH-1:0] sb1_a, sb1_b, sb1_c, sb1_d, sb1_e;
  logic [EXW-1:0] sb1_ap, sb1_bp, sb1_cp, sb1_dp, sb1_ep;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  keccak_chi_ctrl #(.D(D), .ROWS(ROWS)) dut (
    .clk(clk), .rst_i(rst_n), .start(start), .in_rows(in_rows),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .sb_a(sb_a), .sb_b(sb_b), .sb_c(sb_c), .sb_d(sb_d), .sb_e(sb_e), .sb_r(sb_r),
    .sb_ap(sb_ap), .sb_bp(sb_bp), .sb_cp(sb_cp), .sb_dp(sb_dp), .sb_ep(sb_ep),
    .out_rows(out_rows), .busy(busy), .done(done)
  );

  keccak_chi_ctrl #(.D(D), .ROWS(1)) dut1 (
    .clk(clk), .rst_i(rst_n), .start(start1), .in_rows(in_rows1),
    .rnd_valid(rnd_valid1), .rnd_data(rnd_data1), .rnd_ready(rnd_ready1),
    .sb_a(sb1_a), .sb_b(sb1_b), .sb_c(sb1_c), .sb_d(sb1_d), .sb_e(sb1_e), .sb_r(sb_r1),
    .sb_ap(sb1_ap), .sb_bp(sb1_bp), .sb_cp(sb1_cp), .sb_dp(sb1_dp), .sb_ep(sb1_ep),
    .out_rows(out_rows1), .busy(busy1), .done(done1)
  );

  function automatic int pidx(input int i, input int j);
    return i*SH - i*(i+1)/2 + (j - i - 1);
  endfunction

  // Expanded sharing of x ^ (~y & z): cross terms carry a fresh mask that
  // appears twice, so the XOR of all 16 bits equals the unmasked result.
  function automatic logic [EXW-1:0] lane_exp(input logic [SH-1:0] x, input logic [SH-1:0] y,
                                              input logic [SH-1:0] z, input logic [5:0] r);
    logic [SH-1:0] ny;
    logic [EXW-1:0] e;
    ny = y ^ 4'b0001;
    for (int i = 0; i < SH; i++) begin
      for (int j = 0; j < SH; j++) begin
        if (i == j)     e[i*SH+j] = x[i] ^ (ny[i] & z[i]);
        else if (i < j) e[i*SH+j] = (ny[i] & z[j]) ^ r[pidx(i, j)];
        else            e[i*SH+j] = (ny[i] & z[j]) ^ r[pidx(j, i)];
      end
    end
    return e;
  endfunction

  assign sb_ap = lane_exp(sb_a, sb_b, sb_c, sb_r[5:0]);
  assign sb_bp = lane_exp(sb_b, sb_c, sb_d, sb_r[11:6]);
  assign sb_cp = lane_exp(sb_c, sb_d, sb_e, sb_r[17:12]);
  assign sb_dp = lane_exp(sb_d, sb_e, sb_a, sb_r[23:18]);
  assign sb_ep = lane_exp(sb_e, sb_a, sb_b, sb_r[29:24]);

  assign sb1_ap = lane_exp(sb1_a, sb1_b, sb1_c, sb_r1[5:0]);
  assign sb1_bp = lane_exp(sb1_b, sb1_c, sb1_d, sb_r1[11:6]);
  assign sb1_cp = lane_exp(sb1_c, sb1_d, sb1_e, sb_r1[17:12]);
  assign sb1_dp = lane_exp(sb1_d, sb1_e, sb1_a, sb_r1[23:18]);
  assign sb1_ep = lane_exp(sb1_e, sb1_a, sb1_b, sb_r1[29:24]);

  function automatic logic [4:0] chi5(input logic [4:0] v);
    logic [4:0] o;
    for (int l = 0; l < 5; l++) o[l] = v[l] ^ (~v[(l+1)%5] & v[(l+2)%5]);
    return o;
  endfunction

  function automatic logic [4:0] unmask_row(input logic [RW-1:0] r);
    logic [4:0] u;
    for (int l = 0; l < 5; l++) u[l] = ^r[l*SH +: SH];
    return u;
  endfunction

  function automatic logic [39:0] unmask_all(input logic [W-1:0] r);
    logic [39:0] u;
    for (int n = 0; n < ROWS; n++) u[n*5 +: 5] = unmask_row(r[n*RW +: RW]);
    return u;
  endfunction

  function automatic logic [39:0] chi_all(input logic [W-1:0] r);
    logic [39:0] u;
    for (int n = 0; n < ROWS; n++) u[n*5 +: 5] = chi5(unmask_row(r[n*RW +: RW]));
    return u;
  endfunction

  function automatic logic [RW-1:0] share_row(input logic [4:0] v);
    logic [RW-1:0] r;
    logic [SH-1:0] s;
    for (int l = 0; l < 5; l++) begin
      s = 4'($urandom);
      s[3] = v[l] ^ s[0] ^ s[1] ^ s[2];
      r[l*SH +: SH] = s;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] share_const(input logic [4:0] v);
    logic [W-1:0] r;
    for (int n = 0; n < ROWS; n++) r[n*RW +: RW] = share_row(v);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job on the ROWS=8 instance; in_rows is scrambled after the latch.
  task automatic run_job(input logic [W-1:0] rows, input int sr, input int sn, input int start2,
                         output int dcyc, output int ndone, output int hs);
    logic [W-1:0] prev;
    @(negedge clk);
    prev = out_rows;
    in_rows = rows;
    start = 1'b1;
    rnd_valid = 1'b1;
    rnd_data = 30'($urandom);
    dcyc = -1;
    ndone = 0;
    hs = 0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      start = (start2 != 0 && k == start2) ? 1'b1 : 1'b0;
      in_rows = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rnd_data = 30'($urandom);
      rnd_valid = (k >= 1 + 3*sr && k < 1 + 3*sr + sn) ? 1'b0 : 1'b1;
      if (!rnd_valid) check("stall_rdy", 64'(rnd_ready), 64'd1);
      if (rnd_ready && rnd_valid) hs++;
      if (k == 4) check("hold_rows", 64'(out_rows[W-1:RW] == prev[W-1:RW]), 64'd1);
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = k;
      end
      if (dcyc >= 0 && k > dcyc + 3) break;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rows;
    logic [W-1:0] snap;
    logic [RW-1:0] rows1;
    int dcyc, ndone, hs, nd, sr, sn;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdy", 64'(rnd_ready), 64'd0);
    check("rst_out", 64'(out_rows == '0), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // All rows a=1, others 0 -> a'=1, d'=1
    rows = share_const(5'b00001);
    run_job(rows, -1, 0, 0, dcyc, ndone, hs);
    check("basic_done_cyc", 64'(dcyc), 64'd25);
    check("basic_ndone", 64'(ndone), 64'd1);
    check("basic_hs", 64'(hs), 64'd8);
    check("basic_out", unmask_all(out_rows), {8{5'b01001}});

    // Outputs hold while idle
    snap = out_rows;
    repeat (5) @(negedge clk);
    check("idle_hold", 64'(out_rows == snap), 64'd1);

    // Four-cycle stall in row 3 fetch
    rows = share_const(5'b00001);
    run_job(rows, 3, 4, 0, dcyc, ndone, hs);
    check("stall_done_cyc", 64'(dcyc), 64'd29);
    check("stall_hs", 64'(hs), 64'd8);
    check("stall_out", unmask_all(out_rows), {8{5'b01001}});

    // Second start during the job is ignored
    rows = share_const(5'b10110);
    run_job(rows, -1, 0, 5, dcyc, ndone, hs);
    check("restart_done_cyc", 64'(dcyc), 64'd25);
    check("restart_ndone", 64'(ndone), 64'd1);
    check("restart_out", unmask_all(out_rows), {8{5'b00010}});

    // Asynchronous reset in cycle T+10
    rows = share_const(5'b00001);
    @(negedge clk);
    in_rows = rows;
    start = 1'b1;
    rnd_valid = 1'b1;
    nd = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
    end
    check("rst_busy_pre", 64'(busy), 64'd1);
    check("rst_out_pre", 64'(out_rows != '0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rdy", 64'(rnd_ready), 64'd0);
    check("arst_sbr", 64'(sb_r), 64'd0);
    check("arst_out", 64'(out_rows == '0), 64'd1);
    check("arst_done", 64'(done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("arst_no_done", 64'(nd), 64'd0);
    check("arst_idle", 64'(busy), 64'd0);
    rows = share_const(5'b00001);
    run_job(rows, -1, 0, 0, dcyc, ndone, hs);
    check("post_rst_done_cyc", 64'(dcyc), 64'd25);
    check("post_rst_out", unmask_all(out_rows), {8{5'b01001}});

    // ROWS=1 instance: a=0,b=1,c=1,d=0,e=1 -> b'=1 only
    rows1 = share_row(5'b10110);
    @(negedge clk);
    in_rows1 = rows1;
    start1 = 1'b1;
    rnd_valid1 = 1'b1;
    rnd_data1 = 30'($urandom);
    @(negedge clk);
    start1 = 1'b0;
    in_rows1 = 20'($urandom);
    check("r1_rdy_t1", 64'(rnd_ready1), 64'd1);
    check("r1_done_t1", 64'(done1), 64'd0);
    @(negedge clk);
    check("r1_rdy_t2", 64'(rnd_ready1), 64'd0);
    @(negedge clk);
    check("r1_out_t3", 64'(out_rows1), 64'd0);
    check("r1_done_t3", 64'(done1), 64'd0);
    check("r1_rdy_t3", 64'(rnd_ready1), 64'd0);
    @(negedge clk);
    check("r1_out_t4", 64'(unmask_row(out_rows1)), 64'd2);
    check("r1_done_t4", 64'(done1), 64'd1);
    @(negedge clk);
    check("r1_done_t5", 64'(done1), 64'd0);

    // Random jobs with random short stalls
    for (int j = 0; j < 1000; j++) begin
      for (int n = 0; n < ROWS; n++) rows[n*RW +: RW] = share_row(5'($urandom));
      sr = $urandom_range(0, 7);
      sn = $urandom_range(0, 2);
      run_job(rows, sr, sn, 0, dcyc, ndone, hs);
      check("rand_out", unmask_all(out_rows), chi_all(rows));
      check("rand_hs", 64'(hs), 64'd8);
      check("rand_done_cyc", 64'(dcyc), 64'(25 + sn));
      hs_cnt += hs;
    end
    check("rand_hs_total", 64'(hs_cnt), 64'd8000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
